// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: accepts one opcode per handshake and walks it through
// DECODE/EXEC/MEM/WB, driving register-bank, writeback-select, ALU and RAM strobes.
module multicycle_control_unit #(
  parameter int OP_W    = 3,
  parameter int ALU_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [OP_W-1:0]  op_code,
  output logic             instr_ready,
  input  logic             mem_ready,
  output logic             wEnable_BR,
  output logic             SEL_dmx,
  output logic [ALU_W-1:0] OP_alu,
  output logic             W_ram,
  output logic             R_ram,
  output logic             busy,
  output logic             done,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [2:0]       state_dbg
);

  // Handshake: an opcode transfers on a rising edge where instr_valid && instr_ready;
  // instr_ready is high only in IDLE and never depends on instr_valid.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [OP_W-1:0] op_q;
  logic [7:0]      cnt_q, cnt_nx, cnt_inc;
  logic            illegal_q, illegal_nx, tmo_q, tmo_nx;
  logic [31:0]     op_ext;
  logic [3:0]      alu_code;
  logic            is_alu, is_sw, is_lw, is_nop, is_ill;

  assign op_ext  = 32'(op_q);
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    alu_code = 4'b0000;
    is_alu   = 1'b0;
    is_sw    = 1'b0;
    is_lw    = 1'b0;
    is_nop   = 1'b0;
    is_ill   = 1'b0;
    case (op_ext)
      32'd0:   begin alu_code = 4'b0010; is_alu = 1'b1; end
      32'd1:   begin alu_code = 4'b0110; is_alu = 1'b1; end
      32'd2:   begin alu_code = 4'b0111; is_alu = 1'b1; end
      32'd3:   begin alu_code = 4'b1111; is_sw  = 1'b1; end
      32'd4:   begin alu_code = 4'b0111; is_lw  = 1'b1; end
      32'd5:   is_nop = 1'b1;
      default: is_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      cnt_q     <= 8'd0;
      illegal_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt_q     <= cnt_nx;
      illegal_q <= illegal_nx;
      tmo_q     <= tmo_nx;
      if (state == S_IDLE && instr_valid) op_q <= op_code;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt_q;
    illegal_nx  = illegal_q;
    tmo_nx      = tmo_q;
    instr_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    wEnable_BR  = 1'b0;
    SEL_dmx     = 1'b0;
    W_ram       = 1'b0;
    R_ram       = 1'b0;
    OP_alu      = (state == S_IDLE) ? '0 : ALU_W'(alu_code);
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          illegal_nx = 1'b0;
          tmo_nx     = 1'b0;
          state_nx   = S_DECODE;
        end
      end
      S_DECODE: begin
        busy = 1'b1;
        if (is_ill) begin
          illegal_nx = 1'b1;
          done       = 1'b1;
          state_nx   = S_IDLE;
        end else if (is_nop) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end else if (is_sw || is_lw) begin
          cnt_nx   = 8'd0;
          state_nx = S_MEM;
        end else if (is_alu) begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        busy     = 1'b1;
        state_nx = S_WB;
      end
      S_MEM: begin
        busy    = 1'b1;
        W_ram   = is_sw;
        R_ram   = is_lw;
        SEL_dmx = is_sw;
        // A ready RAM wins over an expiring timeout in the same cycle.
        if (mem_ready) begin
          if (is_sw) begin
            done     = 1'b1;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_WB;
          end
        end else begin
          cnt_nx = cnt_inc;
          if (cnt_inc == 8'(TIMEOUT)) begin
            tmo_nx   = 1'b1;
            done     = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      S_WB: begin
        busy       = 1'b1;
        wEnable_BR = 1'b1;
        SEL_dmx    = is_lw;
        done       = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign illegal_op  = illegal_q;
  assign mem_timeout = tmo_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed table-driven bench for multicycle_control_unit plus hand-written
// reset-abort sequence.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [2:0] op_code = 3'd0;
  logic       instr_ready;
  logic       mem_ready = 1'b0;
  logic       wEnable_BR, SEL_dmx, W_ram, R_ram, busy, done, illegal_op, mem_timeout;
  logic [3:0] OP_alu;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  multicycle_control_unit #(.OP_W(3), .ALU_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .op_code(op_code),
    .instr_ready(instr_ready), .mem_ready(mem_ready), .wEnable_BR(wEnable_BR),
    .SEL_dmx(SEL_dmx), .OP_alu(OP_alu), .W_ram(W_ram), .R_ram(R_ram),
    .busy(busy), .done(done), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic [2:0] op;
    int         lat;       // MEM cycles with mem_ready low before it rises
    int         done_cyc;
    int         we;
    logic       sel;
    int         r;
    int         w;
    logic       chk_alu;
    logic [3:0] alu;
    logic       ill;
    logic       tmo;
  } vec_t;

  vec_t vecs[15];

  // driver: issue one instruction and observe it until retirement
  task automatic run_vec(input int idx, input vec_t v);
    int cyc, mem_idx, r_cnt, w_cnt, we_cnt, done_cyc, alu_bad, excl_bad, selm_bad;
    logic sel_we, ill_c1, tmo_c1;
    string tag;
    tag = $sformatf("v%0d_op%0d", idx, v.op);
    cyc = 0; mem_idx = 0; r_cnt = 0; w_cnt = 0; we_cnt = 0; done_cyc = -1;
    alu_bad = 0; excl_bad = 0; selm_bad = 0; sel_we = 1'b0; ill_c1 = 1'b0; tmo_c1 = 1'b0;
    exp_q.push_back(8'(v.done_cyc));
    @(negedge clk);
    instr_valid = 1'b1;
    op_code     = v.op;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    op_code     = 3'($urandom_range(0, 7));
    while (done_cyc < 0 && cyc < 40) begin
      cyc++;
      mem_ready = (mem_idx >= v.lat);
      @(negedge clk);
      if (cyc == 1) begin
        ill_c1 = illegal_op;
        tmo_c1 = mem_timeout;
      end
      if (R_ram) begin r_cnt++; mem_idx++; end
      if (W_ram) begin
        w_cnt++; mem_idx++;
        if (!SEL_dmx) selm_bad++;
      end
      if (wEnable_BR) begin we_cnt++; sel_we = SEL_dmx; end
      if (32'(R_ram) + 32'(W_ram) + 32'(wEnable_BR) > 1) excl_bad++;
      if (v.chk_alu && OP_alu != v.alu) alu_bad++;
      if (done) done_cyc = cyc;
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, int'(exp_q.pop_front()));
    check({tag, "_cleared_on_accept"}, int'({ill_c1, tmo_c1}), 0);
    check({tag, "_we_cycles"}, we_cnt, v.we);
    if (v.we > 0) check({tag, "_sel_dmx_wb"}, int'(sel_we), int'(v.sel));
    check({tag, "_r_ram_cycles"}, r_cnt, v.r);
    check({tag, "_w_ram_cycles"}, w_cnt, v.w);
    if (v.w > 0) check({tag, "_sel_dmx_store"}, selm_bad, 0);
    if (v.chk_alu) check({tag, "_op_alu"}, alu_bad, 0);
    check({tag, "_strobe_excl"}, excl_bad, 0);
    @(negedge clk);
    check({tag, "_ready_after"}, int'(instr_ready), 1);
    check({tag, "_idle_alu"}, int'(OP_alu), 0);
    check({tag, "_illegal_op"}, int'(illegal_op), int'(v.ill));
    check({tag, "_mem_timeout"}, int'(mem_timeout), int'(v.tmo));
  endtask

  initial begin
    //           op    lat   done we sel  r   w chk  alu     ill   tmo
    vecs[0]  = '{3'd0, 0,    3,   1, 1'b0, 0, 0, 1'b1, 4'h2, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 0,    3,   1, 1'b0, 0, 0, 1'b1, 4'h6, 1'b0, 1'b0};
    vecs[2]  = '{3'd2, 0,    3,   1, 1'b0, 0, 0, 1'b1, 4'h7, 1'b0, 1'b0};
    vecs[3]  = '{3'd3, 0,    2,   0, 1'b0, 0, 1, 1'b1, 4'hF, 1'b0, 1'b0};
    vecs[4]  = '{3'd3, 2,    4,   0, 1'b0, 0, 3, 1'b1, 4'hF, 1'b0, 1'b0};
    vecs[5]  = '{3'd4, 0,    3,   1, 1'b1, 1, 0, 1'b1, 4'h7, 1'b0, 1'b0};
    vecs[6]  = '{3'd4, 3,    6,   1, 1'b1, 4, 0, 1'b1, 4'h7, 1'b0, 1'b0};
    vecs[7]  = '{3'd4, 1000, 16,  0, 1'b0, 15, 0, 1'b1, 4'h7, 1'b0, 1'b1};
    vecs[8]  = '{3'd0, 0,    3,   1, 1'b0, 0, 0, 1'b1, 4'h2, 1'b0, 1'b0};
    vecs[9]  = '{3'd4, 14,   17,  1, 1'b1, 15, 0, 1'b1, 4'h7, 1'b0, 1'b0};
    vecs[10] = '{3'd3, 15,   16,  0, 1'b0, 0, 15, 1'b1, 4'hF, 1'b0, 1'b1};
    vecs[11] = '{3'd7, 0,    1,   0, 1'b0, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[12] = '{3'd5, 0,    1,   0, 1'b0, 0, 0, 1'b1, 4'h0, 1'b0, 1'b0};
    vecs[13] = '{3'd6, 0,    1,   0, 1'b0, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[14] = '{3'd1, 0,    3,   1, 1'b0, 0, 0, 1'b1, 4'h6, 1'b0, 1'b0};

    // reset state
    #12;
    check("reset_ready", int'(instr_ready), 1);
    check("reset_outputs",
          int'({wEnable_BR, SEL_dmx, OP_alu, W_ram, R_ram, busy, done, illegal_op, mem_timeout}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // reset mid-MEM during a store: everything drops without a clock edge
    begin
      int done_seen;
      done_seen = 0;
      @(negedge clk);
      instr_valid = 1'b1;
      op_code     = 3'd3;
      mem_ready   = 1'b0;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_mem_w_ram_before", int'(W_ram), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_mem_strobes", int'({W_ram, R_ram, wEnable_BR}), 0);
      check("rst_mid_mem_ready", int'(instr_ready), 1);
      check("rst_mid_mem_done_busy", int'({done, busy}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done || W_ram || busy) done_seen++;
      end
      check("rst_mid_mem_no_resume", done_seen, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor to the single-cycle opcode decoder in the datapath.
- Accepts one instruction opcode per valid/ready handshake.
- Sequences it through DECODE, EXEC, MEM and WB states.
- Drives register-bank write enable, writeback demux select, ALU operation and RAM read/write strobes.
- Waits on a RAM ready handshake with a bounded timeout.
- Flags illegal opcodes and memory timeouts.

Parameters:
- OP_W, 3, opcode width; opcodes at or above 6 are illegal.
- ALU_W, 4, width of OP_alu; must be at least 4. The ALU codes below are zero-extended to ALU_W.
- TIMEOUT, 15, maximum MEM-state cycles without mem_ready before abort; range 1 to 255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  op_code is valid.
- op_code  in  OP_W  instruction opcode.
- instr_ready  out  1  unit can accept an instruction.
- mem_ready  in  1  RAM has completed the current access.
- wEnable_BR  out  1  register-bank write enable.
- SEL_dmx  out  1  writeback select: 0 = ALU result, 1 = RAM data.
- OP_alu  out  ALU_W  ALU operation.
- W_ram  out  1  RAM write strobe.
- R_ram  out  1  RAM read strobe.
- busy  out  1  an instruction is in flight.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  sticky flag: last accepted opcode was illegal.
- mem_timeout  out  1  sticky flag: last memory access timed out.

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE; latched opcode and timeout counter clear to 0.
  - All outputs are 0 except instr_ready = 1.
  - Reset mid-instruction aborts it; no done pulse and no further strobes.
- Opcode table (ALU code, class):
  - 0 ADD: 0010, ALU.
  - 1 SUB: 0110, ALU.
  - 2 SLT: 0111, ALU.
  - 3 SW: 1111, store.
  - 4 LW: 0111, load.
  - 5 NOP: 0000, none.
  - 6 and up: illegal.
- Output timing:
  - Outputs are decoded from the registered state and latched opcode; there is no combinational path from op_code to any output.
  - OP_alu holds the latched opcode's ALU code in every state except IDLE, where it is 0.
- IDLE:
  - instr_ready = 1, busy = 0.
  - On instr_valid: latch op_code, clear illegal_op and mem_timeout, go to DECODE.
- DECODE (1 cycle), busy = 1:
  - ALU op goes to EXEC.
  - SW or LW goes to MEM and clears the timeout counter.
  - NOP goes to IDLE with done = 1.
  - Illegal opcode sets illegal_op and goes to IDLE with done = 1; no strobes.
- EXEC (1 cycle): goes to WB.
- MEM:
  - Store asserts W_ram; load asserts R_ram. The strobe stays high every MEM cycle until the exit.
  - Counter increments each cycle that mem_ready = 0.
  - mem_ready = 1 exits on that cycle: store goes to IDLE with done = 1; load goes to WB.
  - mem_ready has priority over timeout on the same cycle.
  - Counter reaching TIMEOUT with mem_ready = 0: set mem_timeout, go to IDLE with done = 1, no writeback.
- WB (1 cycle):
  - wEnable_BR = 1.
  - SEL_dmx = 1 for a load, 0 for an ALU op.
  - Goes to IDLE with done = 1.
- Store: SEL_dmx = 1 during MEM; wEnable_BR is never asserted.
- Strobe exclusivity: W_ram, R_ram and wEnable_BR are never high together.
- Latency from the handshake edge (cycle 0):
  - ALU op: WB and done at cycle 3.
  - Load with mem_ready in its first MEM cycle: WB at cycle 3.
  - NOP or illegal: done at cycle 1.
- Back-to-back: done is asserted in the state exiting to IDLE. instr_ready is high in the following IDLE cycle, so throughput is at most one instruction per (latency + 1) cycles.
- Flags: illegal_op and mem_timeout stay set until the next accepted instruction or reset.

Test Plan:
- Reset: assert rst_n = 0 mid-MEM with W_ram = 1 -> all strobes 0 and instr_ready = 1 immediately, with no clock edge; no done pulse.
- ALU op: op_code = 1 accepted at cycle 0 -> OP_alu = 0110 at cycles 1-3; wEnable_BR = 1, SEL_dmx = 0 and done = 1 at cycle 3 only; instr_ready = 1 at cycle 4.
- Load with wait: op_code = 4, mem_ready low 3 cycles then high -> R_ram = 1 for 4 cycles; next cycle wEnable_BR = 1, SEL_dmx = 1, done = 1.
- Store: op_code = 3, mem_ready = 1 in first MEM cycle -> W_ram = 1 for 1 cycle, OP_alu = 1111, done on that cycle, wEnable_BR never 1.
- Timeout: op_code = 4, mem_ready held 0, TIMEOUT = 15 -> R_ram high exactly 15 cycles; mem_timeout = 1 and done = 1; no wEnable_BR. Next accepted instruction clears mem_timeout.
- Illegal and NOP: op_code = 7 -> illegal_op = 1, done at cycle 1, no strobes. Then op_code = 5 -> illegal_op cleared on acceptance, done at cycle 1.
